// File: rtl/mem_stage_mc.sv
// Multi-cycle data-memory stage: owns the data array, stalls upstream for LATENCY
// cycles per access and selects the write-back value. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_stage_mc #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] alu_result,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] wb_data
);

  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic [DATA_W-1:0]       data_q;
  logic [DATA_W-1:0]       acc_data;
  logic [DATA_W-1:0]       rdata;
  logic                    op_write;
  logic                    err_q;
  logic                    req;
  logic                    misalign;
  logic                    accept;
  logic                    busy_fire;
  logic                    do_write;
  logic                    do_read;
  logic                    unused_bits;
  logic [DATA_W-1:0]       mem [WORDS];

  assign req    = rd_en | wr_en;
  assign accept = (state == IDLE) && req;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = addr[0];
  assign err      = err_q;
`else
  assign misalign = 1'b0;
  assign err      = 1'b0;
`endif

  assign unused_bits = ^{addr[ADDR_W-1:DEPTH_LOG2+1], addr[0], err_q};

  // The access fires on the edge where the counter would reach zero, so done
  // lands exactly LATENCY cycles after the request.
  assign busy_fire = (state == BUSY) && (cnt == CNT_W'(1));

  always_comb begin
    do_write = 1'b0;
    do_read  = 1'b0;
    acc_idx  = idx_q;
    acc_data = data_q;
    if (LATENCY == 1) begin
      // Single-cycle latency skips BUSY, so the access uses the live request.
      do_write = ~rst & accept & wr_en & ~misalign;
      do_read  = ~rst & accept & ~wr_en & ~misalign;
      acc_idx  = addr[DEPTH_LOG2:1];
      acc_data = wr_data;
    end else begin
      do_write = ~rst & busy_fire & op_write;
      do_read  = ~rst & busy_fire & ~op_write;
    end
  end

  // Array contents survive reset; writes happen only on the completing edge.
  always_ff @(posedge clk) begin
    if (do_write) mem[acc_idx] <= acc_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      op_write <= 1'b0;
      rdata    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (do_read) rdata <= mem[acc_idx];
      case (state)
        IDLE: begin
          if (req) begin
            idx_q    <= addr[DEPTH_LOG2:1];
            data_q   <= wr_data;
            op_write <= wr_en;
            cnt      <= CNT_W'(LATENCY - 1);
            if (misalign) begin
              state <= DONE;
              err_q <= 1'b1;
              if (!wr_en) rdata <= '0;
            end else if (LATENCY == 1) begin
              state <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (busy_fire) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall   = ~rst & (accept | (state == BUSY));
  assign done    = (state == DONE);
  assign wb_data = ((state == DONE) && !op_write) ? rdata : alu_result;

endmodule

// File: tb/tb_mem_stage_mc.sv
// Self-checking bench for mem_stage_mc: scoreboard of expected write-back results,
// with a reference memory model; honours MEM_ALIGN_CHECK_EN when defined.
module tb_mem_stage_mc;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic        wr_en;
  logic [15:0] alu_result;
  logic        stall;
  logic        done;
  logic        err;
  logic [15:0] wb_data;

  typedef struct {
    logic [15:0] wb;
    logic        err;
    int          lat;
  } sb_t;

  sb_t         sb_q[$];
  logic [15:0] model [1024];
  int          checks = 0;
  int          errors = 0;

  mem_stage_mc #(
    .DATA_W(16),
    .ADDR_W(16),
    .DEPTH_LOG2(10),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .wr_data(wr_data),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .alu_result(alu_result),
    .stall(stall),
    .done(done),
    .err(err),
    .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_access(input logic we, input logic re, input logic [15:0] a,
                           input logic [15:0] d, input logic [15:0] alu, input string name);
    sb_t         e;
    int          k;
    bit          got;
    bit          mis;
    logic [9:0]  idx;
`ifdef MEM_ALIGN_CHECK_EN
    mis = a[0];
`else
    mis = 1'b0;
`endif
    idx   = a[10:1];
    e.lat = mis ? 1 : LAT;
    e.err = mis;
    if (we) begin
      e.wb = alu;
      if (!mis) model[idx] = d;
    end else begin
      e.wb = mis ? 16'h0000 : model[idx];
    end
    sb_q.push_back(e);
    wr_en = we; rd_en = re; addr = a; wr_data = d; alu_result = alu;
    k = 0;
    got = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        e = sb_q.pop_front();
        checks++;
        if (k !== e.lat) begin
          errors++;
          $display("FAIL %s latency: got %0d want %0d", name, k, e.lat);
        end
        checks++;
        if (stall !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_in_done: got %b want 0", name, stall);
        end
        checks++;
        if (wb_data !== e.wb) begin
          errors++;
          $display("FAIL %s wb_data: got %h want %h", name, wb_data, e.wb);
        end
        checks++;
        if (err !== e.err) begin
          errors++;
          $display("FAIL %s err: got %b want %b", name, err, e.err);
        end
      end else begin
        checks++;
        if (stall !== 1'b1) begin
          errors++;
          $display("FAIL %s stall_cycle%0d: got %b want 1", name, k, stall);
        end
      end
      @(posedge clk);
      #1;
      k++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done want done within 20 cycles", name);
      void'(sb_q.pop_front());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_en = 1'b1; wr_en = 1'b0; addr = 16'h0000; wr_data = 16'h0000;
    alu_result = 16'h1234;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL reset stall: got %b want 0", stall); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", err); end
      checks++;
      if (wb_data !== 16'h1234) begin
        errors++; $display("FAIL reset wb_data: got %h want 1234", wb_data);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle stall_done: got %b%b want 00", stall, done);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load();
    do_access(1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h1111, "store_beef");
    do_access(1'b0, 1'b1, 16'h0010, 16'h0000, 16'h2222, "load_beef");
  endtask

  task automatic test_wrap();
    do_access(1'b1, 1'b0, 16'h0002, 16'hA5A5, 16'h3333, "store_wrap");
    do_access(1'b0, 1'b1, 16'h0802, 16'h0000, 16'h4444, "load_wrap");
  endtask

  task automatic test_both_en();
    do_access(1'b1, 1'b1, 16'h0020, 16'h0F0F, 16'h5A5A, "both_en");
    do_access(1'b0, 1'b1, 16'h0020, 16'h0000, 16'h6666, "load_both_en");
  endtask

  task automatic test_reset_mid_store();
    do_access(1'b1, 1'b0, 16'h0030, 16'h1111, 16'h0000, "pre_store");
    wr_en = 1'b1; addr = 16'h0030; wr_data = 16'h7777; alu_result = 16'h0000;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL midrst stall0: got %b want 1", stall); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL midrst cycle1: got done=%b stall=%b want 0 0", done, stall);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL midrst no_done: got %b want 0", done); end
    @(posedge clk);
    #1;
    do_access(1'b0, 1'b1, 16'h0030, 16'h0000, 16'h0000, "load_after_rst");
  endtask

  task automatic test_misaligned();
    do_access(1'b1, 1'b0, 16'h0031, 16'h5555, 16'hCAFE, "mis_store");
    do_access(1'b0, 1'b1, 16'h0031, 16'h0000, 16'hCAFE, "mis_load");
    do_access(1'b0, 1'b1, 16'h0030, 16'h0000, 16'hD00D, "aligned_after_mis");
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      a = 16'h0100 + 16'(2 * i);
      v = 16'($urandom);
      do_access(1'b1, 1'b0, a, v, 16'($urandom), "b2b_init");
    end
    for (int i = 0; i < 12; i++) begin
      a = 16'h0100 + 16'(2 * $urandom_range(0, 3));
      v = 16'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_access(1'b1, 1'b0, a, v, 16'($urandom), "b2b_store");
      else
        do_access(1'b0, 1'b1, a, v, 16'($urandom), "b2b_load");
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_wrap();
    test_both_en();
    test_reset_mid_store();
    test_misaligned();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
